// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
//   Constants and the round-robin grant helper shared by the four-bit mux
//   arbiter and its datapath mux.
//   Contents:
//     DATA_WIDTH    payload width of the four_bit_2x1_mux datapath (4)
//     REQ_0/REQ_1   requester index constants
//     grant_t       grant decision {valid, idx}
//     grant_select  two-way round-robin decision from the valids and last winner
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int   DATA_WIDTH = 4;
  localparam logic REQ_0      = 1'b0;
  localparam logic REQ_1      = 1'b1;

  typedef struct packed {
    logic valid;  // some requester is granted
    logic idx;    // which requester is granted
  } grant_t;

  // On a tie the requester that did not win last time goes next.
  function automatic grant_t grant_select(input logic v0, input logic v1,
                                          input logic last_grant);
    grant_t g;
    g.valid = v0 | v1;
    case ({v1, v0})
      2'b01:   g.idx = REQ_0;
      2'b10:   g.idx = REQ_1;
      2'b11:   g.idx = ~last_grant;
      default: g.idx = REQ_0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/four_bit_2x1_mux.sv
// ---------------------------------------------------------------------------
// four_bit_2x1_mux
//   Plain 2:1 multiplexer for a 4-bit word.
//   Ports:
//     In_1    in  [3:0]  word chosen when Select=1
//     In_0    in  [3:0]  word chosen when Select=0
//     Select  in  1      source index
//     Out     out [3:0]  selected word (combinational)
// ---------------------------------------------------------------------------
module four_bit_2x1_mux
  import mux_arb_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] In_1,
  input  logic [DATA_WIDTH-1:0] In_0,
  input  logic                  Select,
  output logic [DATA_WIDTH-1:0] Out
);

  // Select the word from the requested source.
  always_comb begin
    if (Select) begin
      Out = In_1;
    end else begin
      Out = In_0;
    end
  end

endmodule

// File: rtl/four_bit_mux_arbiter.sv
// ---------------------------------------------------------------------------
// four_bit_mux_arbiter
//   Round-robin arbiter sharing one four_bit_2x1_mux between two 4-bit
//   producers. The grant drives the mux select; the selected word is captured
//   in a 1-deep output register and offered downstream with valid/ready.
//   Optional feature macro: MUX_ARB_STATS_EN adds saturating per-requester
//   grant counters (parameter STAT_WIDTH, default 8).
//   Ports:
//     Clk, Reset                  clock, synchronous active-high reset
//     In_0_Valid/In_0/In_0_Ready  requester 0 handshake and data
//     In_1_Valid/In_1/In_1_Ready  requester 1 handshake and data
//     Out_Valid/Out/Out_Ready     downstream handshake and registered data
//     Select                      source index of the word held in Out
//     Grant_Count_0/1             transfers accepted per requester
//                                 (MUX_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module four_bit_mux_arbiter
  import mux_arb_pkg::*;
`ifdef MUX_ARB_STATS_EN
  #(parameter int STAT_WIDTH = 8)
`endif
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  In_0_Valid,
  input  logic [DATA_WIDTH-1:0] In_0,
  output logic                  In_0_Ready,
  input  logic                  In_1_Valid,
  input  logic [DATA_WIDTH-1:0] In_1,
  output logic                  In_1_Ready,
  output logic                  Out_Valid,
  output logic [DATA_WIDTH-1:0] Out,
  input  logic                  Out_Ready,
  output logic                  Select
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] Grant_Count_0,
  output logic [STAT_WIDTH-1:0] Grant_Count_1
`endif
);

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_select;
  logic                  r_last_grant;

  logic                  w_load_en;
  grant_t                w_grant;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_mux_out;

  // The output register can take a new word when empty or being drained now.
  assign w_load_en = !r_out_valid || Out_Ready;
  assign w_grant   = grant_select(In_0_Valid, In_1_Valid, r_last_grant);
  assign w_xfer    = w_load_en && w_grant.valid;

  // Ready is only offered to the granted requester, so at most one is high.
  assign In_0_Ready = w_xfer && (w_grant.idx == REQ_0) && In_0_Valid;
  assign In_1_Ready = w_xfer && (w_grant.idx == REQ_1) && In_1_Valid;

  four_bit_2x1_mux u_mux (
    .In_1   (In_1),
    .In_0   (In_0),
    .Select (w_grant.idx),
    .Out    (w_mux_out)
  );

  // Output stage and arbitration history. Out/Select keep the last word after
  // it is consumed; only Out_Valid drops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out_valid  <= 1'b0;
      r_out        <= {DATA_WIDTH{1'b0}};
      r_select     <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_xfer) begin
      r_out_valid  <= 1'b1;
      r_out        <= w_mux_out;
      r_select     <= w_grant.idx;
      r_last_grant <= w_grant.idx;
    end else if (Out_Ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign Out_Valid = r_out_valid;
  assign Out       = r_out;
  assign Select    = r_select;

`ifdef MUX_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] r_grant_count_0;
  logic [STAT_WIDTH-1:0] r_grant_count_1;

  // Saturating grant counters, one step per accepted transfer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_grant_count_0 <= {STAT_WIDTH{1'b0}};
      r_grant_count_1 <= {STAT_WIDTH{1'b0}};
    end else begin
      if (In_0_Ready && (r_grant_count_0 != {STAT_WIDTH{1'b1}})) begin
        r_grant_count_0 <= r_grant_count_0 + STAT_WIDTH'(1);
      end
      if (In_1_Ready && (r_grant_count_1 != {STAT_WIDTH{1'b1}})) begin
        r_grant_count_1 <= r_grant_count_1 + STAT_WIDTH'(1);
      end
    end
  end

  assign Grant_Count_0 = r_grant_count_0;
  assign Grant_Count_1 = r_grant_count_1;
`endif

endmodule

// File: tb/tb_four_bit_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_four_bit_mux_arbiter
//   Self-checking bench: directed scenarios with literal expectations followed
//   by randomized traffic, all compared every cycle against a behavioural
//   model (a one-slot output buffer plus a "whose turn" flag).
// ---------------------------------------------------------------------------
module tb_four_bit_mux_arbiter;

  localparam int SW = 2;
  localparam int SAT = (1 << SW) - 1;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       In_0_Valid, In_1_Valid, Out_Ready;
  logic [3:0] In_0, In_1;
  logic       In_0_Ready, In_1_Ready, Out_Valid, Select;
  logic [3:0] Out;
`ifdef MUX_ARB_STATS_EN
  logic [SW-1:0] Grant_Count_0, Grant_Count_1;
`endif

  always #5 Clk = ~Clk;

`ifdef MUX_ARB_STATS_EN
  four_bit_mux_arbiter #(.STAT_WIDTH(SW)) dut (
`else
  four_bit_mux_arbiter dut (
`endif
    .Clk(Clk), .Reset(Reset),
    .In_0_Valid(In_0_Valid), .In_0(In_0), .In_0_Ready(In_0_Ready),
    .In_1_Valid(In_1_Valid), .In_1(In_1), .In_1_Ready(In_1_Ready),
    .Out_Valid(Out_Valid), .Out(Out), .Out_Ready(Out_Ready),
    .Select(Select)
`ifdef MUX_ARB_STATS_EN
    , .Grant_Count_0(Grant_Count_0), .Grant_Count_1(Grant_Count_1)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Model: a single buffered word (or none), the word last shown on Out,
  // who won most recently, and grant tallies.
  bit       m_full;
  bit [3:0] m_data;
  bit       m_src;
  bit       m_last_winner;
  int       m_cnt0, m_cnt1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit v0, input bit [3:0] d0,
                       input bit v1, input bit [3:0] d1, input bit ordy);
    Reset = rst; In_0_Valid = v0; In_0 = d0; In_1_Valid = v1; In_1 = d1; Out_Ready = ordy;
  endtask

  // Who the model would grant right now, and whether a grant happens at all.
  task automatic model_decide(output bit grant, output bit winner);
    bit room;
    room = !m_full || Out_Ready;
    if (In_0_Valid && In_1_Valid) winner = !m_last_winner;
    else if (In_1_Valid)          winner = 1'b1;
    else                          winner = 1'b0;
    grant = room && (In_0_Valid || In_1_Valid);
  endtask

  // One clock: compare every output at the falling edge, then advance the model.
  task automatic step();
    bit grant, winner;
    @(negedge Clk);
    model_decide(grant, winner);
    chk("out_valid", Out_Valid, m_full);
    chk("out",       Out,       m_data);
    chk("select",    Select,    m_src);
    chk("in0_ready", In_0_Ready, grant && winner == 1'b0);
    chk("in1_ready", In_1_Ready, grant && winner == 1'b1);
`ifdef MUX_ARB_STATS_EN
    chk("grant_cnt0", Grant_Count_0, 8'(m_cnt0));
    chk("grant_cnt1", Grant_Count_1, 8'(m_cnt1));
`endif
    @(posedge Clk);
    if (Reset) begin
      m_full = 0; m_data = 0; m_src = 0; m_last_winner = 1; m_cnt0 = 0; m_cnt1 = 0;
    end else if (grant) begin
      m_full = 1;
      m_data = winner ? In_1 : In_0;
      m_src = winner;
      m_last_winner = winner;
      if (winner) m_cnt1 = (m_cnt1 < SAT) ? m_cnt1 + 1 : SAT;
      else        m_cnt0 = (m_cnt0 < SAT) ? m_cnt0 + 1 : SAT;
    end else if (Out_Ready) begin
      m_full = 0;
    end
    #1;
  endtask

  bit [3:0] exp_seq [4];
  bit       exp_sel [4];

  initial begin
    m_full = 0; m_data = 0; m_src = 0; m_last_winner = 1; m_cnt0 = 0; m_cnt1 = 0;
    drive(1, 0, 4'h0, 0, 4'h0, 0);
    @(posedge Clk); #1;
    step();
    // Reset state literals.
    chk("rst_out_valid", Out_Valid, 1'b0);
    chk("rst_out", Out, 4'h0);
    chk("rst_select", Select, 1'b0);

    // 1: single request from requester 0.
    drive(0, 1, 4'b0101, 0, 4'h0, 1);
    #1;
    chk("t1_in0_ready", In_0_Ready, 1'b1);
    step();
    chk("t1_out", Out, 4'b0101);
    chk("t1_select", Select, 1'b0);
    chk("t1_out_valid", Out_Valid, 1'b1);

    // 2: sustained dual requests from reset alternate starting with 0.
    drive(1, 0, 4'h0, 0, 4'h0, 0);
    step();
    drive(0, 1, 4'b0101, 1, 4'b1010, 1);
    exp_seq[0] = 4'b0101; exp_seq[1] = 4'b1010; exp_seq[2] = 4'b0101; exp_seq[3] = 4'b1010;
    exp_sel[0] = 1'b0; exp_sel[1] = 1'b1; exp_sel[2] = 1'b0; exp_sel[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_out", Out, exp_seq[i]);
      chk("t2_select", Select, exp_sel[i]);
    end

    // 3: stall with both requesting; nothing moves.
    drive(0, 1, 4'b0101, 1, 4'b1010, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_in0_ready", In_0_Ready, 1'b0);
      chk("t3_in1_ready", In_1_Ready, 1'b0);
      step();
      chk("t3_out", Out, 4'b1010);
      chk("t3_select", Select, 1'b1);
    end
    Out_Ready = 1;
    step();
    chk("t3_resume_out", Out, 4'b0101);
    chk("t3_resume_select", Select, 1'b0);

    // 4: requester 1 only, consumer ready 1,0,1.
    drive(0, 0, 4'h0, 1, 4'b1111, 1);
    step();
    chk("t4_out_a", Out, 4'b1111);
    chk("t4_valid_a", Out_Valid, 1'b1);
    Out_Ready = 0;
    step();
    chk("t4_out_b", Out, 4'b1111);
    chk("t4_valid_b", Out_Valid, 1'b1);
    Out_Ready = 1;
    step();
    chk("t4_valid_c", Out_Valid, 1'b1);
    chk("t4_select_c", Select, 1'b1);

    // 5: reset with a word pending, then a tie goes to requester 0.
    drive(1, 1, 4'b0011, 1, 4'b1100, 0);
    step();
    chk("t5_out_valid", Out_Valid, 1'b0);
    chk("t5_out", Out, 4'h0);
    chk("t5_select", Select, 1'b0);
    drive(0, 1, 4'b0011, 1, 4'b1100, 1);
    step();
    chk("t5_tie_out", Out, 4'b0011);
    chk("t5_tie_select", Select, 1'b0);

`ifdef MUX_ARB_STATS_EN
    // 6: counter saturation.
    drive(1, 0, 4'h0, 0, 4'h0, 1);
    step();
    drive(0, 1, 4'h6, 0, 4'h0, 1);
    for (int i = 0; i < 5; i++) step();
    chk("t6_cnt0", Grant_Count_0, 8'(3));
    chk("t6_cnt1", Grant_Count_1, 8'(0));
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
